muldiv_resp_queue: RTL and testbench

MULDIV_RESP_QUEUE -- requirements
Module: muldiv_resp_queue

---
 rtl/muldiv_resp_queue.sv | 111 +++++++++++
 tb/tb_muldiv_resp_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_resp_queue.sv
// muldiv_resp_queue
//   Small in-order FIFO between the multiply/divide unit's response port and a
//   shared register-file write port. It also tracks which destination
//   registers still have a multiply/divide result outstanding.
//
// Parameters
//   DEPTH  result-queue entries (power of two, 2..8)
//   XLEN   result data width
//
// Ports
//   clk, reset_n                     clock; asynchronous active-low reset
//   io_issue_valid / io_issue_tag    a request for register io_issue_tag starts
//   io_kill                          squash the most recently issued request
//   io_enq_*                         result from the mul/div unit (valid/ready)
//   io_wb_*                          register-file write request (valid/ready)
//   io_busy[31:0]                    bit n set: register n awaits a result
//
// Build option
//   MULDIV_RESP_BYPASS_EN  when defined, a result arriving at an empty queue is
//                          presented on io_wb_* in the same cycle.
module muldiv_resp_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            io_issue_valid,
  input  logic [4:0]      io_issue_tag,
  input  logic            io_kill,
  output logic            io_enq_ready,
  input  logic            io_enq_valid,
  input  logic [XLEN-1:0] io_enq_bits_data,
  input  logic [4:0]      io_enq_bits_tag,
  output logic            io_wb_valid,
  input  logic            io_wb_ready,
  output logic [XLEN-1:0] io_wb_data,
  output logic [4:0]      io_wb_tag,
  output logic [31:0]     io_busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage is deliberately not reset; it is only read when count_q != 0.
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [4:0]      mem_tag  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic [4:0]    last_tag_q, last_tag_d;

  logic enq_fire, wb_fire, bypass, mem_write, mem_pop;

  always_comb begin
    io_enq_ready = (count_q != FULL_CNT);
    enq_fire     = io_enq_valid & io_enq_ready;
`ifdef MULDIV_RESP_BYPASS_EN
    // Gated by reset_n so io_wb_valid stays low throughout reset.
    bypass = reset_n & (count_q == '0) & io_enq_valid & (io_enq_bits_tag != 5'd0);
`else
    bypass = 1'b0;
`endif
    io_wb_valid = (count_q != '0) | bypass;
    io_wb_data  = bypass ? io_enq_bits_data : mem_data[rd_ptr_q];
    io_wb_tag   = bypass ? io_enq_bits_tag  : mem_tag[rd_ptr_q];
    io_busy     = busy_q;
    wb_fire     = io_wb_valid & io_wb_ready;

    // Tag 0 results are accepted and dropped (x0 is never written).
    // A bypassed result consumed this cycle never touches storage; a bypassed
    // result that is not taken is stored normally and re-presented from there.
    mem_write = enq_fire & (io_enq_bits_tag != 5'd0) & ~(bypass & io_wb_ready);
    mem_pop   = wb_fire & ~bypass;

    wr_ptr_d = mem_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = mem_pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(mem_write) - CW'(mem_pop);

    // Priority low to high: writeback clear, kill clear, issue set.
    busy_d = busy_q;
    if (wb_fire) busy_d[io_wb_tag] = 1'b0;
    if (io_kill) busy_d[last_tag_q] = 1'b0;
    if (io_issue_valid && io_issue_tag != 5'd0) busy_d[io_issue_tag] = 1'b1;
    last_tag_d = io_issue_valid ? io_issue_tag : last_tag_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      last_tag_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      last_tag_q <= last_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem_data[wr_ptr_q] <= io_enq_bits_data;
      mem_tag[wr_ptr_q]  <= io_enq_bits_tag;
    end
  end
endmodule

// File: tb/tb_muldiv_resp_queue.sv
// Directed bench for muldiv_resp_queue. Two instances (DEPTH 2 and DEPTH 4)
// share all inputs; results are predicted into a scoreboard queue when driven
// and compared when the write port takes them.
module tb_muldiv_resp_queue;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        issue_valid, kill, enq_valid, wb_ready;
  logic [4:0]  issue_tag, enq_tag;
  logic [31:0] enq_data;

  logic        enq_ready2, wb_valid2, enq_ready4, wb_valid4;
  logic [31:0] wb_data2, wb_data4, busy2, busy4;
  logic [4:0]  wb_tag2, wb_tag4;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
  } ent_t;
  ent_t sb[$];

  always #5 clk = ~clk;

  muldiv_resp_queue #(.DEPTH(2), .XLEN(32)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .io_issue_valid(issue_valid), .io_issue_tag(issue_tag), .io_kill(kill),
    .io_enq_ready(enq_ready2), .io_enq_valid(enq_valid),
    .io_enq_bits_data(enq_data), .io_enq_bits_tag(enq_tag),
    .io_wb_valid(wb_valid2), .io_wb_ready(wb_ready),
    .io_wb_data(wb_data2), .io_wb_tag(wb_tag2), .io_busy(busy2)
  );

  muldiv_resp_queue #(.DEPTH(4), .XLEN(32)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .io_issue_valid(issue_valid), .io_issue_tag(issue_tag), .io_kill(kill),
    .io_enq_ready(enq_ready4), .io_enq_valid(enq_valid),
    .io_enq_bits_data(enq_data), .io_enq_bits_tag(enq_tag),
    .io_wb_valid(wb_valid4), .io_wb_ready(wb_ready),
    .io_wb_data(wb_data4), .io_wb_tag(wb_tag4), .io_busy(busy4)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic [4:0] t, input logic [31:0] d, input bit push);
    enq_valid = 1'b1;
    enq_tag   = t;
    enq_data  = d;
    if (push) sb.push_back('{tag: t, data: d});
  endtask

  // Compare the head presented by one instance against the scoreboard head.
  task automatic cmp_head(input string nm, input logic v, input logic [4:0] t,
                          input logic [31:0] d);
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", nm);
    end else begin
      chk({nm, "_vld"}, 64'(v), 64'd1);
      chk({nm, "_tag"}, 64'(t), 64'(sb[0].tag));
      chk({nm, "_dat"}, 64'(d), 64'(sb[0].data));
    end
  endtask

  task automatic pop2(input string nm);
    cmp_head(nm, wb_valid2, wb_tag2, wb_data2);
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    issue_valid = 1'b0; issue_tag = '0; kill = 1'b0;
    enq_valid = 1'b0; enq_tag = '0; enq_data = '0; wb_ready = 1'b0;

    #2 reset_n = 1'b0;
    #1;
    chk("rst_wbv2",  64'(wb_valid2),  64'd0);
    chk("rst_rdy2",  64'(enq_ready2), 64'd1);
    chk("rst_busy2", 64'(busy2),      64'd0);
    chk("rst_wbv4",  64'(wb_valid4),  64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

`ifdef MULDIV_RESP_BYPASS_EN
    wb_ready = 1'b1;
    drive_enq(5'd3, 32'hCAFE_0003, 1'b0);
    #1;
    chk("byp_vld", 64'(wb_valid2), 64'd1);
    chk("byp_tag", 64'(wb_tag2),   64'd3);
    chk("byp_dat", 64'(wb_data2),  64'hCAFE_0003);
    tick();
    enq_valid = 1'b0;
    #1;
    chk("byp_cnt0", 64'(wb_valid2), 64'd0);
    chk("byp_rdy",  64'(enq_ready2), 64'd1);
`else
    // Single result, immediate consumer: one cycle of latency.
    wb_ready = 1'b1;
    drive_enq(5'd5, 32'h1234_5678, 1'b1);
    #1;
    chk("lat_same_cycle", 64'(wb_valid2), 64'd0);
    tick();
    enq_valid = 1'b0;
    pop2("lat1");
    tick();
    chk("lat_empty", 64'(wb_valid2), 64'd0);

    // Backpressure: DEPTH 2 fills, third result refused, order kept.
    wb_ready = 1'b0;
    drive_enq(5'd1, 32'hA000_0001, 1'b1);
    tick();
    drive_enq(5'd2, 32'hA000_0002, 1'b1);
    tick();
    drive_enq(5'd3, 32'hA000_0003, 1'b0);
    chk("full_rdy",  64'(enq_ready2), 64'd0);
    chk("hold_tag",  64'(wb_tag2),    64'd1);
    tick();
    enq_valid = 1'b0;
    chk("hold_tag2", 64'(wb_tag2),  64'd1);
    chk("hold_dat2", 64'(wb_data2), 64'hA000_0001);
    wb_ready = 1'b1;
    pop2("order_a");
    tick();
    pop2("order_b");
    tick();
    chk("drain_empty", 64'(wb_valid2), 64'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Scoreboard: set beats clear on the same bit.
    issue_valid = 1'b1; issue_tag = 5'd7;
    tick();
    issue_valid = 1'b0;
    chk("busy7", 64'(busy2), 64'h80);
    drive_enq(5'd7, 32'h0000_0077, 1'b1);
    tick();
    enq_valid = 1'b0;
    issue_valid = 1'b1; issue_tag = 5'd7;
    pop2("pop7a");
    tick();
    issue_valid = 1'b0;
    chk("set_wins", 64'(busy2), 64'h80);
    drive_enq(5'd7, 32'h0000_0078, 1'b1);
    tick();
    enq_valid = 1'b0;
    pop2("pop7b");
    tick();
    chk("busy7_clr", 64'(busy2), 64'h0);

    // Kill, tag 0 issue, kill-vs-issue, tag 0 result.
    issue_valid = 1'b1; issue_tag = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk("busy9", 64'(busy2), 64'h200);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill9", 64'(busy2), 64'h0);
    issue_valid = 1'b1; issue_tag = 5'd9;
    tick();
    issue_tag = 5'd0;
    tick();
    issue_valid = 1'b0;
    chk("issue_tag0", 64'(busy2), 64'h200);
    issue_valid = 1'b1; issue_tag = 5'd12;
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0; issue_valid = 1'b0;
    chk("kill_vs_issue", 64'(busy2), 64'h1200);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill12", 64'(busy2), 64'h200);
    drive_enq(5'd0, 32'hDEAD_0000, 1'b0);
    chk("enq0_rdy", 64'(enq_ready2), 64'd1);
    tick();
    enq_valid = 1'b0;
    chk("enq0_drop", 64'(wb_valid2), 64'd0);
    tick();
    chk("enq0_drop2", 64'(wb_valid2), 64'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Streaming enqueue/pop pairs: pointers wrap several times.
    wb_ready = 1'b1;
    drive_enq(5'($urandom_range(31, 1)), $urandom, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      cmp_head($sformatf("wrap4_%0d", i), wb_valid4, wb_tag4, wb_data4);
      pop2($sformatf("wrap2_%0d", i));
      drive_enq(5'($urandom_range(31, 1)), $urandom, 1'b1);
      tick();
    end
    enq_valid = 1'b0;
    cmp_head("wrap4_last", wb_valid4, wb_tag4, wb_data4);
    pop2("wrap2_last");
    tick();
    chk("wrap_empty", 64'(wb_valid4), 64'd0);

    // Reset in the middle of traffic drops results and busy bits at once.
    wb_ready = 1'b0;
    issue_valid = 1'b1; issue_tag = 5'd4;
    drive_enq(5'd6, 32'h0000_0606, 1'b1);
    tick();
    issue_valid = 1'b0; enq_valid = 1'b0;
    chk("mid_vld", 64'(wb_valid4), 64'd1);
    chk("mid_busy", 64'(busy4), 64'h10);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_vld",  64'(wb_valid4),  64'd0);
    chk("mid_rst_busy", 64'(busy4),      64'd0);
    chk("mid_rst_rdy",  64'(enq_ready4), 64'd1);
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_vld", 64'(wb_valid4), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
